dvs_aer_event_receiver: RTL and testbench
=========================================

// Module: dvs_aer_event_receiver
// PURPOSE
//  Parametrised successor AER receiver between the DVS camera and the RAVENS event path. Synchronises async REQ
//  and waits a settle window before sampling data. Handshakes Y (row) and X (column+polarity) words; stamps each
//  event with a microsecond timestamp. Buffers completed events in a FIFO drained by a valid/ready consumer.
//  Selectable full policy: drop-and-count or stall ACK.
// PARAMETERS
//  X_BITS        9    X address width
//  Y_BITS        9    Y address width
//  AER_BITS      10   AER bus width; must be >= max(X_BITS+1, Y_BITS)
//  TS_BITS       32   timestamp width (us), wraps modulo 2^TS_BITS
//  CLK_FREQ_MHZ  100  clk cycles per microsecond (prescaler terminal count)
//  SYNC_STAGES   2    REQ synchroniser depth, >=2
//  SETTLE_CYCLES 6    cycles after synced REQ high before data sampled (>=50ns incl. sync)
//  FIFO_DEPTH    16   event FIFO depth, power of 2, >=2
//  DROP_ON_FULL  1    1: drop event + count when FIFO full; 0: hold ACK low until space
// PORTS
//  clk             in   1         system clock
//  rst_n           in   1         asynchronous active-low reset
//  aer             in   AER_BITS  AER data bus (async to clk)
//  xsel            in   1         1 = X word, 0 = Y word (async)
//  req             in   1         sender request (async)
//  ack             out  1         receiver acknowledge
//  event_x         out  X_BITS    FIFO head: column
//  event_y         out  Y_BITS    FIFO head: row
//  event_timestamp out  TS_BITS   FIFO head: timestamp (us)
//  event_polarity  out  1         FIFO head: polarity
//  event_valid     out  1         FIFO non-empty
//  event_ready     in   1         consumer pops head when valid&&ready
//  drop_count      out  16        saturating count of dropped events (DROP_ON_FULL=1)
// BEHAVIOUR
//  Reset (async assert, sync deassert): ack=0, event_valid=0, event_* =0, drop_count=0, timestamp=0,
//   prescaler=0, row register=0, ts_latched flag=0, FSM=IDLE, FIFO empty. Reset mid-handshake drops the word.
//  Timestamp: prescaler counts 0..CLK_FREQ_MHZ-1; timestamp increments on terminal count; wraps to 0.
//  FSM: IDLE -> SETTLE when synced REQ=1; SETTLE counts SETTLE_CYCLES -> CAPTURE;
//   CAPTURE samples aer/xsel in one cycle and acts per word type:
//    Y word: row<=aer[Y_BITS-1:0]; ts_lat<=timestamp captured at IDLE->SETTLE; ts_latched<=1 -> ACK_HI.
//    X word: x=aer[X_BITS:1], pol=aer[0]; ts = ts_latched ? ts_lat : this word's IDLE->SETTLE stamp;
//     push {x,row,ts,pol}; clear ts_latched -> ACK_HI.
//     FIFO full: DROP_ON_FULL=1 -> discard, drop_count+1 (saturate 16'hFFFF) -> ACK_HI;
//     DROP_ON_FULL=0 -> stay CAPTURE (ack=0) until space, then push.
//   ACK_HI: ack=1 (registered); wait synced REQ=0 -> ACK_LO. ACK_LO: ack=0 one cycle -> IDLE.
//  Back-to-back X words after one Y reuse row; only the first takes the Y-latched stamp.
//  FIFO: push and pop same cycle when full permits push (net occupancy unchanged); pop on empty ignored.
//   Outputs show head combinationally from storage; first event_valid 1 cycle after push.
//  Latency REQ rise -> ack rise: SYNC_STAGES+SETTLE_CYCLES+2 cycles.
// STRUCTURE
//  dvs_ravens_pkg: add aer_event_t struct {x,y,timestamp,polarity}, aer_rx_state_t enum
//   {IDLE,SETTLE,CAPTURE,ACK_HI,ACK_LO}, and default width constants (DVS_X_ADDR_BITS etc.).
//  Sub-module aer_event_fifo (parametrised width/depth, ptrs with extra wrap bit, full/empty flags).
// TESTING
//  Reset: hold rst_n=0 with req=1 -> ack=0, event_valid=0, drop_count=0; ack asserts only after release.
//  Y=9'h0A5 then X={9'h123,1} at t=5us -> head x=0x123, y=0x0A5, pol=1, ts in {4,5,6}; ack rise >=50ns after req rise.
//  Row burst: Y=3, then X=10,11,12 -> three events y=3; first uses Y stamp, others their own; same order.
//  Full, DROP_ON_FULL=1, ready=0: 20 events -> 16 stored, drop_count=4, ack never stalls.
//  Full, DROP_ON_FULL=0: 17th X word -> ack held 0 until one pop, then event 17 stored, drop_count=0.
//  Wrap: TS_BITS=8, run 300us -> timestamps wrap 255->0; concurrent push/pop at full keeps count at 16.

Source files
------------

// File: rtl/dvs_ravens_pkg.sv
// Shared types and default widths for the DVS-to-RAVENS event path.
package dvs_ravens_pkg;

  localparam int unsigned DVS_X_ADDR_BITS   = 9;
  localparam int unsigned DVS_Y_ADDR_BITS   = 9;
  localparam int unsigned DVS_AER_BITS      = 10;
  localparam int unsigned DVS_TS_BITS       = 32;
  localparam int unsigned DVS_CLK_FREQ_MHZ  = 100;
  localparam int unsigned DVS_SYNC_STAGES   = 2;
  localparam int unsigned DVS_SETTLE_CYCLES = 6;
  localparam int unsigned DVS_FIFO_DEPTH    = 16;

  // Event layout at default widths; the receiver packs the same field order.
  typedef struct packed {
    logic [DVS_X_ADDR_BITS-1:0] x;
    logic [DVS_Y_ADDR_BITS-1:0] y;
    logic [DVS_TS_BITS-1:0]     timestamp;
    logic                       polarity;
  } aer_event_t;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StCapture,
    StAckHi,
    StAckLo
  } aer_rx_state_t;

endpackage

// File: rtl/aer_event_fifo.sv
// Synchronous event FIFO; head is read combinationally from storage.
module aer_event_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [AddrW:0]   wptr_q, rptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic             push_ok, pop_ok;

  assign empty_o = (wptr_q == rptr_q);
  // Same index with differing wrap bits means the writer lapped the reader.
  assign full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign rdata_o = mem_q[rptr_q[AddrW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_q[wptr_q[AddrW-1:0]] <= wdata_i;
        wptr_q <= wptr_q + (AddrW+1)'(1);
      end
      if (pop_ok) begin
        rptr_q <= rptr_q + (AddrW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/dvs_aer_event_receiver.sv
// AER receiver: synchronised REQ, settle window, Y/X word handshake, timestamped event FIFO.
module dvs_aer_event_receiver
  import dvs_ravens_pkg::*;
#(
  parameter int unsigned X_BITS        = DVS_X_ADDR_BITS,
  parameter int unsigned Y_BITS        = DVS_Y_ADDR_BITS,
  parameter int unsigned AER_BITS      = DVS_AER_BITS,
  parameter int unsigned TS_BITS       = DVS_TS_BITS,
  parameter int unsigned CLK_FREQ_MHZ  = DVS_CLK_FREQ_MHZ,
  parameter int unsigned SYNC_STAGES   = DVS_SYNC_STAGES,
  parameter int unsigned SETTLE_CYCLES = DVS_SETTLE_CYCLES,
  parameter int unsigned FIFO_DEPTH    = DVS_FIFO_DEPTH,
  parameter bit          DROP_ON_FULL  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [AER_BITS-1:0] aer,
  input  logic                xsel,
  input  logic                req,
  output logic                ack,
  output logic [X_BITS-1:0]   event_x,
  output logic [Y_BITS-1:0]   event_y,
  output logic [TS_BITS-1:0]  event_timestamp,
  output logic                event_polarity,
  output logic                event_valid,
  input  logic                event_ready,
  output logic [15:0]         drop_count
);

  localparam int unsigned EventW  = X_BITS + Y_BITS + TS_BITS + 1;
  localparam int unsigned PrescW  = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
  localparam int unsigned SettleW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [PrescW-1:0]  PrescLast  = PrescW'(CLK_FREQ_MHZ - 1);
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYCLES - 1);

  aer_rx_state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] req_sync_q;
  logic                   req_synced;
  logic [PrescW-1:0]      presc_q;
  logic [TS_BITS-1:0]     ts_q, stamp_q, ts_lat_q, ev_ts;
  logic [SettleW-1:0]     settle_q;
  logic [Y_BITS-1:0]      row_q;
  logic                   ts_latched_q;
  logic [15:0]            drop_q;
  logic                   capture_x, fifo_push, fifo_pop, drop_evt;
  logic                   fifo_full, fifo_empty;
  logic [EventW-1:0]      fifo_wdata, fifo_rdata;

  assign req_synced = req_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_sync_q <= '0;
      presc_q    <= '0;
      ts_q       <= '0;
    end else begin
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], req};
      if (presc_q == PrescLast) begin
        presc_q <= '0;
        ts_q    <= ts_q + TS_BITS'(1);
      end else begin
        presc_q <= presc_q + PrescW'(1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (req_synced) state_d = StSettle;
      StSettle:  if (settle_q == SettleLast) state_d = StCapture;
      StCapture: if (!xsel || fifo_push || drop_evt) state_d = StAckHi;
      StAckHi:   if (!req_synced) state_d = StAckLo;
      StAckLo:   state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    capture_x = (state_q == StCapture) && xsel;
    ack       = (state_q == StAckHi);
    fifo_push = capture_x && (!fifo_full || fifo_pop);
    // Without drop mode a full FIFO simply holds the FSM in capture.
    drop_evt  = capture_x && fifo_full && !fifo_pop && DROP_ON_FULL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stamp_q      <= '0;
      settle_q     <= '0;
      row_q        <= '0;
      ts_lat_q     <= '0;
      ts_latched_q <= 1'b0;
      drop_q       <= '0;
    end else begin
      if (state_q == StIdle && req_synced) begin
        stamp_q  <= ts_q;
        settle_q <= '0;
      end else if (state_q == StSettle) begin
        settle_q <= settle_q + SettleW'(1);
      end
      if (state_q == StCapture && !xsel) begin
        row_q        <= aer[Y_BITS-1:0];
        ts_lat_q     <= stamp_q;
        ts_latched_q <= 1'b1;
      end else if (fifo_push || drop_evt) begin
        ts_latched_q <= 1'b0;
      end
      if (drop_evt && drop_q != 16'hFFFF) begin
        drop_q <= drop_q + 16'd1;
      end
    end
  end

  assign ev_ts      = ts_latched_q ? ts_lat_q : stamp_q;
  assign fifo_wdata = {aer[X_BITS:1], row_q, ev_ts, aer[0]};
  assign fifo_pop   = event_valid && event_ready;

  aer_event_fifo #(
    .Width(EventW),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .push_i (fifo_push),
    .wdata_i(fifo_wdata),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_rdata),
    .empty_o(fifo_empty),
    .full_o (fifo_full)
  );

  assign event_valid = !fifo_empty;
  assign drop_count  = drop_q;
  assign {event_x, event_y, event_timestamp, event_polarity} = fifo_rdata;

endmodule

// File: tb/tb_dvs_aer_event_receiver.sv
// Bench: dut_a (drop mode, 32-bit stamps) checked every cycle against a queue model;
// dut_b (stall mode, 8-bit stamps) checked with directed expectations.
module tb_dvs_aer_event_receiver;

  localparam int CLK = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [9:0]  aer;
  logic        xsel, req_a, req_b, rdy_a, rdy_b;
  logic        ack_a, ack_b, pol_a, pol_b, ev_a, ev_b;
  logic [8:0]  ex_a, ey_a, ex_b, ey_b;
  logic [31:0] ets_a;
  logic [7:0]  ets_b;
  logic [15:0] drop_a, drop_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  dvs_aer_event_receiver #(
    .DROP_ON_FULL(1'b1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .aer(aer), .xsel(xsel), .req(req_a), .ack(ack_a),
    .event_x(ex_a), .event_y(ey_a), .event_timestamp(ets_a), .event_polarity(pol_a),
    .event_valid(ev_a), .event_ready(rdy_a), .drop_count(drop_a)
  );

  dvs_aer_event_receiver #(
    .TS_BITS(8),
    .DROP_ON_FULL(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .aer(aer), .xsel(xsel), .req(req_b), .ack(ack_b),
    .event_x(ex_b), .event_y(ey_b), .event_timestamp(ets_b), .event_polarity(pol_b),
    .event_valid(ev_b), .event_ready(rdy_b), .drop_count(drop_b)
  );

  always @(posedge clk) if (rst_n) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model of dut_a: row/stamp latch rules and a 16-deep queue with drop-on-full.
  typedef struct { int x; int y; int pol; int ts; } ev_t;
  ev_t mq[$];
  int  row_m = 0, lat_m = 0, drop_m = 0;
  bit  latched_m = 0, ack_prev = 0, rdy_prev = 0;
  bit  cur_is_x = 0;
  int  cur_x = 0, cur_pol = 0, cur_y = 0, cur_stamp = 0;

  initial begin
    forever begin
      ev_t e;
      int  size_before, d;
      bit  popped;
      @(negedge clk);
      if (!rst_n) begin
        ack_prev = 0;
        rdy_prev = 0;
      end else begin
        size_before = mq.size();
        popped = rdy_prev && size_before > 0;
        if (popped) void'(mq.pop_front());
        if (ack_a && !ack_prev) begin
          if (!cur_is_x) begin
            row_m = cur_y; lat_m = cur_stamp; latched_m = 1;
          end else begin
            e.x = cur_x; e.y = row_m; e.pol = cur_pol;
            e.ts = latched_m ? lat_m : cur_stamp;
            latched_m = 0;
            if (size_before < 16 || popped) mq.push_back(e);
            else drop_m++;
          end
        end
        chk("a_valid", ev_a, mq.size() > 0);
        if (mq.size() > 0) begin
          chk("a_head_x", ex_a, mq[0].x);
          chk("a_head_y", ey_a, mq[0].y);
          chk("a_head_pol", pol_a, mq[0].pol);
          d = int'(ets_a) - mq[0].ts;
          chk("a_head_ts_near", (d >= -1 && d <= 1), 1);
        end
        chk("a_drop_count", drop_a, drop_m);
        ack_prev = ack_a;
        rdy_prev = rdy_a;
      end
    end
  end

  task automatic hs(input bit to_b, input bit is_x, input logic [9:0] word, output int lat);
    int w;
    aer = word;
    xsel = is_x;
    if (!to_b) begin
      cur_is_x = is_x; cur_x = int'(word[9:1]); cur_pol = int'(word[0]); cur_y = int'(word[8:0]);
    end
    @(posedge clk); #1;
    if (!to_b) cur_stamp = cyc / CLK;
    if (to_b) req_b = 1'b1; else req_a = 1'b1;
    lat = 0;
    while (((to_b ? ack_b : ack_a) == 1'b0) && lat < 500) begin
      @(posedge clk); #1; lat++;
    end
    if (lat >= 500) begin
      n_checks++; n_fail++;
      $display("FAIL ack_timeout: ack still 0 after %0d cycles, required 1", lat);
    end
    if (to_b) req_b = 1'b0; else req_a = 1'b0;
    w = 0;
    while ((to_b ? ack_b : ack_a) && w < 100) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 100) begin
      n_checks++; n_fail++;
      $display("FAIL ack_release: ack still 1 after %0d cycles, required 0", w);
    end
    @(posedge clk); #1;
  endtask

  task automatic pop_a();
    rdy_a = 1'b1; @(posedge clk); #1; rdy_a = 1'b0;
  endtask

  task automatic pop_b();
    rdy_b = 1'b1; @(posedge clk); #1; rdy_b = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin @(posedge clk); #1; end
  endtask

  initial begin
    int lat, n, last, t0, t1;
    rst_n = 1'b0; aer = '0; xsel = 1'b0;
    req_a = 1'b1; req_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_ack", ack_a, 0);
    chk("rst_valid", ev_a, 0);
    chk("rst_drop", drop_a, 0);
    chk("rst_x", ex_a, 0);
    chk("rst_y", ey_a, 0);
    chk("rst_ts", ets_a, 0);
    chk("rst_pol", pol_a, 0);
    rst_n = 1'b1;
    lat = 0;
    while (!ack_a && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("rst_release_latency", lat, 10);
    req_a = 1'b0;
    n = 0;
    while (ack_a && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;

    // Single Y/X pair around t = 5 us
    wait_cyc(500);
    hs(0, 0, 10'h0A5, lat);
    chk("a_latency_y", lat, 10);
    chk("a_ack_after_50ns", lat * 10 >= 50, 1);
    hs(0, 1, {9'h123, 1'b1}, lat);
    chk("a_latency_x", lat, 10);
    chk("pair_valid", ev_a, 1);
    chk("pair_x", ex_a, 'h123);
    chk("pair_y", ey_a, 'h0A5);
    chk("pair_pol", pol_a, 1);
    chk("pair_ts_4_to_6", (ets_a >= 4 && ets_a <= 6), 1);
    pop_a();

    // Row burst: one Y then three X words
    hs(0, 0, 10'd3, lat);
    repeat (200) @(posedge clk);
    #1;
    hs(0, 1, {9'd10, 1'b0}, lat);
    repeat (200) @(posedge clk);
    #1;
    hs(0, 1, {9'd11, 1'b1}, lat);
    hs(0, 1, {9'd12, 1'b0}, lat);
    chk("burst_x0", ex_a, 10);
    chk("burst_y0", ey_a, 3);
    t0 = int'(ets_a);
    pop_a();
    chk("burst_x1", ex_a, 11);
    chk("burst_y1", ey_a, 3);
    t1 = int'(ets_a);
    chk("burst_own_stamp", t1 - t0 >= 3, 1);
    pop_a();
    chk("burst_x2", ex_a, 12);
    chk("burst_y2", ey_a, 3);
    pop_a();
    chk("burst_empty", ev_a, 0);

    // Overfill in drop mode
    for (int i = 0; i < 20; i++) begin
      hs(0, 1, {9'(100 + i), 1'b0}, lat);
      chk("drop_no_stall_latency", lat, 10);
    end
    chk("drop_count_4", drop_a, 4);
    n = 0; last = -1;
    while (ev_a && n < 40) begin
      if (n == 0) chk("drop_first_x", ex_a, 100);
      last = int'(ex_a);
      pop_a();
      n++;
    end
    chk("drop_stored_16", n, 16);
    chk("drop_last_x", last, 115);

    // Stall mode: 17th word waits for space, pushes with the same-cycle pop
    for (int i = 0; i < 16; i++) begin
      hs(1, 1, {9'(i + 1), 1'b1}, lat);
      if (i == 0) chk("b_latency", lat, 10);
    end
    aer = {9'd17, 1'b1}; xsel = 1'b1;
    @(posedge clk); #1;
    req_b = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("b_stall_ack_low", ack_b, 0);
    chk("b_full_valid", ev_b, 1);
    chk("b_head_x1", ex_b, 1);
    pop_b();
    n = 0;
    while (!ack_b && n < 50) begin @(posedge clk); #1; n++; end
    chk("b_ack_after_pop", ack_b, 1);
    req_b = 1'b0;
    n = 0;
    while (ack_b && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    chk("b_drop_zero", drop_b, 0);
    n = 0;
    while (ev_b && n < 40) begin
      chk("b_order_x", ex_b, n + 2);
      pop_b();
      n++;
    end
    chk("b_count_16", n, 16);

    // Timestamp wrap with 8-bit stamps
    wait_cyc(25300);
    hs(1, 1, {9'd200, 1'b1}, lat);
    wait_cyc(26200);
    hs(1, 1, {9'd201, 1'b1}, lat);
    chk("wrap_pre_x", ex_b, 200);
    chk("wrap_pre_ts", (ets_b >= 252 && ets_b <= 254), 1);
    chk("wrap_y_row0", ey_b, 0);
    pop_b();
    chk("wrap_post_x", ex_b, 201);
    chk("wrap_post_ts", (ets_b >= 5 && ets_b <= 7), 1);
    chk("wrap_post_pol", pol_b, 1);
    pop_b();
    chk("wrap_empty", ev_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
